// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Iteration counter must reach WIDTH, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring step: trial-subtract the divisor from the shifted remainder.
module seq_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] trial;

    always_comb begin
        trial = {rem_i, bit_i} - {1'b0, div_i};
        q_o   = ~trial[WIDTH];
        rem_o = q_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider for RISC-V DIV/DIVU/REM/REMU with
// valid/ready handshakes; divide-by-zero resolves on the accept edge.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             rem_sel_q, rem_sel_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    logic             is_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[WIDTH-1];
    assign b_neg     = is_signed & divisor[WIDTH-1];

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    // The quotient register doubles as the dividend shifter: its MSB feeds the step.
    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (quot_q[WIDTH-1]),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        rem_sel_d = rem_sel_q;
        negq_d    = negq_q;
        negr_d    = negr_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rem_sel_d = op[1];
                    negq_d    = a_neg ^ b_neg;
                    negr_d    = a_neg;
                    quot_d    = a_neg ? -dividend : dividend;
                    dvs_d     = b_neg ? -divisor : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (divisor == '0) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                rem_d  = step_rem;
                quot_d = {quot_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (rem_sel_q) begin
                    result_d = negr_q ? -rem_q : rem_q;
                end else begin
                    result_d = negq_q ? -quot_q : quot_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            quot_q    <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            rem_sel_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            rem_sel_q <= rem_sel_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // RISC-V division semantics computed in 64-bit signed arithmetic.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] o);
        longint sa, sb, q, r;
        if (b == '0) return o[1] ? a : '1;
        if (o[0]) begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[W-1:0] : q[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure accept-to-out_valid edges, check result and retire.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] o, input string tag);
        logic [W-1:0] exp;
        int n;
        exp = model(a, b, o);
        @(negedge clk);
        dividend = a; divisor = b; op = o; in_valid = 1'b1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), (b == '0) ? 64'd1 : 64'(W + 2));
        chk({tag, " result"}, 64'(result), 64'(exp));
        @(posedge clk); #1;
        chk({tag, " retire"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   o;
        int           n;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0; op = OP_DIV;
        #12;
        chk("reset state", 64'({in_ready, out_valid, result}), {31'd0, 1'b1, 1'b0, 32'd0});
        @(negedge clk); rst = 1'b0;

        do_op(32'd100, 32'd7, OP_DIV, "div 100/7");
        do_op(32'd100, 32'd7, OP_REM, "rem 100/7");
        do_op(32'hFFFF_FFF9, 32'd2, OP_DIV, "div -7/2");
        do_op(32'hFFFF_FFF9, 32'd2, OP_REM, "rem -7/2");
        do_op(32'hFFFF_FFFF, 32'h10, OP_DIVU, "divu ffffffff/16");
        do_op(32'hFFFF_FFFF, 32'h10, OP_REMU, "remu ffffffff/16");
        do_op(32'd5, 32'd0, OP_DIV, "div 5/0");
        do_op(32'hFFFF_FFFB, 32'd0, OP_REM, "rem -5/0");
        do_op(32'd0, 32'd0, OP_DIVU, "divu 0/0");
        do_op(32'h1234_5678, 32'd0, OP_REMU, "remu x/0");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, OP_DIV, "div overflow");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, OP_REM, "rem overflow");
        do_op(32'h8000_0000, 32'd1, OP_DIV, "div minneg/1");
        do_op(32'd7, 32'hFFFF_FFFE, OP_REM, "rem 7/-2");

        // Backpressure: result held while out_ready is low, busy requests ignored.
        out_ready = 1'b0;
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; op = OP_DIV; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp latency", 64'(n), 64'(W + 2));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dividend = $urandom; divisor = 32'd3; op = OP_REMU; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp hold", 64'({out_valid, in_ready, result}), {31'd0, 1'b1, 1'b0, 32'd14});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp retire", 64'({out_valid, in_ready}), 64'b01);
        do_op(32'd81, 32'd9, OP_DIVU, "after bp");

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; op = OP_DIV; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async reset", 64'({in_ready, out_valid, result}), {31'd0, 1'b1, 1'b0, 32'd0});
        @(negedge clk); rst = 1'b0;
        do_op(32'd9, 32'd3, OP_DIV, "post reset div 9/3");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1:       b = '1;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            o = 2'($urandom_range(0, 3));
            do_op(a, b, o, $sformatf("rand%0d op%0d %0h/%0h", i, o, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
